// File: rtl/aurora_rx_nfc_buffer.sv
// Receive elastic buffer between the Aurora RX stream and the inbound NoC port.
// It drives NFC XOFF/XON requests to the link partner from FIFO fill watermarks.
module aurora_rx_nfc_buffer #(
    parameter int ADDR_W  = 5,
    parameter int HIGH_WM = 24,
    parameter int LOW_WM  = 8
) (
    input  logic              hs_clock,
    input  logic              pcie_reset_n,
    input  logic              channel_up,
    input  logic              rx_tvalid,
    input  logic [31:0]       rx_tdata,
    output logic              nfc_tvalid,
    input  logic              nfc_tready,
    output logic [3:0]        nfc_tdata,
    output logic              hs_i_noc_bus_valid,
    input  logic              hs_i_noc_bus_ready,
    output logic [31:0]       hs_i_noc_bus_payload,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_C    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] HIGH_C    = (ADDR_W+1)'(HIGH_WM);
    localparam logic [ADDR_W:0] LOW_C     = (ADDR_W+1)'(LOW_WM);
    localparam logic [3:0]      XOFF_CODE = 4'hF;
    localparam logic [3:0]      XON_CODE  = 4'h0;

    typedef enum logic [1:0] {
        XON_IDLE  = 2'd0,
        SEND_XOFF = 2'd1,
        XOFF_HELD = 2'd2,
        SEND_XON  = 2'd3
    } nfc_state_e;

    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    nfc_state_e        state_q, state_d;
    logic              nfc_valid_q, nfc_valid_d;
    logic [3:0]        nfc_data_q, nfc_data_d;
    logic              empty_s, rd_s, wr_req_s, wr_s;

    // Handshake decode; a full FIFO still accepts a word when the head leaves in the same cycle
    always_comb begin
        empty_s  = (cnt_q == {(ADDR_W+1){1'b0}});
        rd_s     = ~empty_s & hs_i_noc_bus_ready;
        wr_req_s = rx_tvalid & channel_up;
        wr_s     = wr_req_s & ((cnt_q != FULL_C) | rd_s);
    end

    // FIFO pointer, occupancy and overflow next state; link down flushes everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (!channel_up) begin
            wr_ptr_d = {ADDR_W{1'b0}};
            rd_ptr_d = {ADDR_W{1'b0}};
            cnt_d    = {(ADDR_W+1){1'b0}};
            ovf_d    = 1'b0;
        end else begin
            wr_ptr_d = wr_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_d = rd_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
            ovf_d    = ovf_q | (wr_req_s & ~wr_s);
            case ({wr_s, rd_s})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // NFC request FSM; a pending request is only left on acceptance or link down
    always_comb begin
        state_d = state_q;
        if (!channel_up) begin
            state_d = XON_IDLE;
        end else begin
            case (state_q)
                XON_IDLE:  state_d = (cnt_q >= HIGH_C) ? SEND_XOFF : XON_IDLE;
                SEND_XOFF: state_d = nfc_tready ? XOFF_HELD : SEND_XOFF;
                XOFF_HELD: state_d = (cnt_q <= LOW_C) ? SEND_XON : XOFF_HELD;
                SEND_XON:  state_d = nfc_tready ? XON_IDLE : SEND_XON;
                default:   state_d = XON_IDLE;
            endcase
        end
        nfc_valid_d = (state_d == SEND_XOFF) || (state_d == SEND_XON);
        nfc_data_d  = (state_d == SEND_XOFF) ? XOFF_CODE : XON_CODE;
    end

    // Control and output registers
    always_ff @(posedge hs_clock or negedge pcie_reset_n) begin
        if (!pcie_reset_n) begin
            wr_ptr_q    <= {ADDR_W{1'b0}};
            rd_ptr_q    <= {ADDR_W{1'b0}};
            cnt_q       <= {(ADDR_W+1){1'b0}};
            ovf_q       <= 1'b0;
            state_q     <= XON_IDLE;
            nfc_valid_q <= 1'b0;
            nfc_data_q  <= XON_CODE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            nfc_valid_q <= nfc_valid_d;
            nfc_data_q  <= nfc_data_d;
        end
    end

    // Storage array; contents are only observable through occupied slots, so no reset
    always_ff @(posedge hs_clock) begin
        if (wr_s) begin
            mem_q[wr_ptr_q] <= rx_tdata;
        end
    end

    assign hs_i_noc_bus_valid   = ~empty_s;
    assign hs_i_noc_bus_payload = empty_s ? 32'h0000_0000 : mem_q[rd_ptr_q];
    assign fill_level           = cnt_q;
    assign overflow             = ovf_q;
    assign nfc_tvalid           = nfc_valid_q;
    assign nfc_tdata            = nfc_data_q;

endmodule

// File: tb/tb_aurora_rx_nfc_buffer.sv
// Randomised scoreboard bench for aurora_rx_nfc_buffer against a queue-based reference model.
module tb_aurora_rx_nfc_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cu = 1'b0;
    logic        rxv = 1'b0;
    logic [31:0] rxd = 32'h0;
    logic        nfc_tvalid;
    logic        nfc_tready = 1'b0;
    logic [3:0]  nfc_tdata;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] payload;
    logic [5:0]  fill;
    logic        ovf;

    aurora_rx_nfc_buffer dut (
        .hs_clock(clk), .pcie_reset_n(rst_n), .channel_up(cu),
        .rx_tvalid(rxv), .rx_tdata(rxd),
        .nfc_tvalid(nfc_tvalid), .nfc_tready(nfc_tready), .nfc_tdata(nfc_tdata),
        .hs_i_noc_bus_valid(valid), .hs_i_noc_bus_ready(ready),
        .hs_i_noc_bus_payload(payload), .fill_level(fill), .overflow(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: FIFO contents as a queue plus occupancy, sticky drop flag,
    // and the partner's pause state with any outstanding NFC request (-1 = none).
    logic [31:0] exp_q[$];
    int  m_cnt = 0;
    bit  m_ovf = 1'b0;
    int  m_pend = -1;
    bit  m_paused = 1'b0;
    int  xoff_acc = 0;
    int  xon_acc = 0;
    int  max_fill = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_nfc_tvalid", 32'(nfc_tvalid), 32'd0);
        check("rst_nfc_tdata", 32'(nfc_tdata), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_payload", payload, 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_overflow", 32'(ovf), 32'd0);
    endtask

    // Reference model: compare registered state, then advance by the rules for this cycle's inputs
    always @(negedge clk) begin
        if (!rst_n) begin
            m_cnt = 0; m_ovf = 1'b0; m_pend = -1; m_paused = 1'b0;
            exp_q.delete();
        end else begin
            check("fill_level", 32'(fill), 32'(m_cnt));
            check("noc_valid", 32'(valid), 32'(m_cnt != 0));
            check("overflow", 32'(ovf), 32'(m_ovf));
            check("nfc_tvalid", 32'(nfc_tvalid), 32'(m_pend >= 0));
            if (m_pend >= 0) check("nfc_tdata", 32'(nfc_tdata), 32'(m_pend));
            if (!cu) begin
                m_cnt = 0; m_ovf = 1'b0; m_pend = -1; m_paused = 1'b0;
                exp_q.delete();
            end else begin
                bit rd_m;
                bit acc_m;
                rd_m  = (m_cnt > 0) && ready;
                acc_m = rxv && ((m_cnt < 32) || rd_m);
                if (m_pend >= 0) begin
                    if (nfc_tready) begin
                        m_paused = (m_pend == 15);
                        m_pend = -1;
                    end
                end else if (!m_paused && m_cnt >= 24) begin
                    m_pend = 15;
                end else if (m_paused && m_cnt <= 8) begin
                    m_pend = 0;
                end
                if (rxv && !acc_m) m_ovf = 1'b1;
                if (acc_m) exp_q.push_back(rxd);
                m_cnt = m_cnt + int'(acc_m) - int'(rd_m);
            end
        end
    end

    // Output monitor: every word the consumer takes must be the next expected one
    always @(negedge clk) begin
        if (rst_n && cu) begin
            if (valid && ready) begin
                if (exp_q.size() == 0) check("unexpected_word", payload, 32'hDEAD_BEEF);
                else check("payload", payload, exp_q.pop_front());
            end
            if (nfc_tvalid && nfc_tready) begin
                if (nfc_tdata == 4'hF) xoff_acc++;
                else xon_acc++;
            end
            if (int'(fill) > max_fill) max_fill = int'(fill);
        end
    end

    task automatic push_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            rxv = 1'b1;
            rxd = (base < 0) ? $urandom : 32'(base + i);
            step();
        end
        rxv = 1'b0;
    endtask

    task automatic drain(input string name);
        ready = 1'b1;
        for (int k = 0; k < 100 && fill != 6'd0; k++) step();
        check(name, 32'(fill), 32'd0);
    endtask

    initial begin
        #12;
        check_reset_values();
        step();
        rst_n = 1'b1;
        cu = 1'b1;
        step();

        // Pass-through with ready held high
        ready = 1'b1;
        max_fill = 0;
        push_words(100, 1);
        repeat (3) step();
        check("pt_max_fill", 32'(max_fill <= 1), 32'd1);
        check("pt_sb_empty", 32'(exp_q.size()), 32'd0);

        // Watermarks: one XOFF held until accepted, then one XON on drain
        ready = 1'b0;
        nfc_tready = 1'b0;
        xoff_acc = 0;
        xon_acc = 0;
        push_words(24, -1);
        for (int k = 0; k < 10 && !nfc_tvalid; k++) step();
        check("wm_xoff_seen", 32'(nfc_tvalid), 32'd1);
        repeat (5) step();
        nfc_tready = 1'b1;
        step();
        nfc_tready = 1'b0;
        check("wm_xoff_count", 32'(xoff_acc), 32'd1);
        ready = 1'b1;
        for (int k = 0; k < 200 && (xon_acc == 0 || fill != 6'd0); k++) begin
            nfc_tready = 1'($urandom % 2);
            step();
        end
        nfc_tready = 1'b0;
        check("wm_xon_count", 32'(xon_acc), 32'd1);
        check("wm_xoff_once", 32'(xoff_acc), 32'd1);

        // Overflow: 40 words into a stalled FIFO, words 33..40 dropped
        ready = 1'b0;
        nfc_tready = 1'b1;
        push_words(40, 1);
        check("ovf_fill", 32'(fill), 32'd32);
        check("ovf_flag", 32'(ovf), 32'd1);
        drain("ovf_drain");
        cu = 1'b0;
        step();
        cu = 1'b1;
        step();

        // Full with simultaneous read accepts the new word
        ready = 1'b0;
        push_words(32, 32'h100);
        check("full_fill", 32'(fill), 32'd32);
        rxv = 1'b1;
        rxd = 32'h0000_ABCD;
        ready = 1'b1;
        step();
        rxv = 1'b0;
        ready = 1'b0;
        check("full_rw_fill", 32'(fill), 32'd32);
        check("full_rw_ovf", 32'(ovf), 32'd0);
        drain("full_drain");

        // Link down while an XOFF request is pending
        ready = 1'b0;
        nfc_tready = 1'b0;
        push_words(24, -1);
        for (int k = 0; k < 10 && !nfc_tvalid; k++) step();
        check("ld_xoff_seen", 32'(nfc_tvalid), 32'd1);
        cu = 1'b0;
        step();
        check("ld_nfc_tvalid", 32'(nfc_tvalid), 32'd0);
        check("ld_fill", 32'(fill), 32'd0);
        check("ld_valid", 32'(valid), 32'd0);
        cu = 1'b1;
        ready = 1'b1;
        push_words(20, -1);
        drain("ld_resume_drain");

        // Random traffic with occasional link drops and one asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            rxv = 1'($urandom % 4 != 0);
            rxd = $urandom;
            ready = ((c / 200) % 2 == 0) ? 1'($urandom % 4 != 0) : 1'($urandom % 3 == 0);
            nfc_tready = 1'($urandom % 3 == 0);
            cu = 1'($urandom % 500 != 0);
            if (c == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_reset_values();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        rxv = 1'b0;
        cu = 1'b1;
        nfc_tready = 1'b1;
        drain("final_drain");
        step();
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
